// File: rtl/qb_pkg.sv
// ============================================================================
// Module   : qb_pkg
// Brief    : Shared types and constants for the qb serial link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qb_pkg;

  // Word width shared by both ends of the link.
  localparam int QB_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } qb_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/piso_shreg.sv
// ============================================================================
// Module   : piso_shreg
// Brief    : Parallel-load shift register that presents one serial bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shreg #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         so_bit
);

  logic [W-1:0] r_shreg;

  // Shift direction moves the next bit onto the output end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_shreg <= '0;
        end else if (load) begin
          r_shreg <= d;
        end else if (shift) begin
          r_shreg <= {r_shreg[W-2:0], 1'b0};
        end
      end
      assign so_bit = r_shreg[W-1];
    end else begin : g_lsb_first
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_shreg <= '0;
        end else if (load) begin
          r_shreg <= d;
        end else if (shift) begin
          r_shreg <= {1'b0, r_shreg[W-1:1]};
        end
      end
      assign so_bit = r_shreg[0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/qb_tx.sv
// ============================================================================
// Module   : qb_tx
// Brief    : qb serial-link transmitter with one-entry holding register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qb_tx
  import qb_pkg::*;
#(
  parameter int W         = QB_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         so,
  output logic         co,
  output logic         busy
);

  localparam int            CW     = $clog2(W);
  localparam logic [CW-1:0] c_last = CW'(W - 1);

  qb_tx_state_t  r_state;
  logic [W-1:0]  r_hold;
  logic          r_hold_valid;
  logic [CW-1:0] r_bit_cnt;

  logic w_last;
  logic w_load;
  logic w_shift;
  logic w_sh_bit;

  assign w_last  = (r_state == SHIFT) && (r_bit_cnt == c_last);
  // Loading from hold on the last bit is what removes the inter-word gap.
  assign w_load  = en && r_hold_valid && ((r_state == IDLE) || w_last);
  assign w_shift = en && (r_state == SHIFT) && !w_last;

  // Accept and load never coincide: accept needs hold empty, load needs it full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_bit_cnt    <= '0;
    end else begin
      if (in_valid && !r_hold_valid) begin
        r_hold       <= in_data;
        r_hold_valid <= 1'b1;
      end
      if (w_load) begin
        r_hold_valid <= 1'b0;
        r_bit_cnt    <= '0;
        r_state      <= SHIFT;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end else if (en && w_last) begin
        r_state <= IDLE;
      end
    end
  end

  piso_shreg #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .shift  (w_shift),
    .d      (r_hold),
    .so_bit (w_sh_bit)
  );

  assign in_ready = ~r_hold_valid;
  assign so       = (r_state == SHIFT) ? w_sh_bit : IDLE_LVL;
  assign co       = w_last;
  assign busy     = (r_state == SHIFT) | r_hold_valid;

endmodule

`default_nettype wire
